// File: rtl/pipe_ctrl_if.sv
// Bundle of the ID/EX status signals seen by the pipeline sequencing
// controller and the run/flush/redirect/trap controls it returns.
//
// Handshake: redirect_valid_o and trap_valid_o have no ready. Fetch loads
// redirect_pc_o and the trap unit commits trap_epc_o/trap_cause_o in the same
// cycle the valid is high. The payloads are zero whenever their valid is low.
interface pipe_ctrl_if #(
    parameter int PC_WIDTH = 32
);
    logic                ID_valid_i;
    logic [PC_WIDTH-1:0] ID_pc_i;
    logic                ID_pc_misalign_i;
    logic                ID_if_bus_err_i;
    logic [4:0]          ID_rs1_i;
    logic [4:0]          ID_rs2_i;
    logic                ID_rs1_used_i;
    logic                ID_rs2_used_i;
    logic                EX_valid_i;
    logic                EX_load_i;
    logic [4:0]          EX_rd_i;
    logic                EX_br_valid_i;
    logic                EX_br_taken_i;
    logic                EX_prdt_taken_i;
    logic [PC_WIDTH-1:0] EX_br_target_i;
    logic [PC_WIDTH-1:0] EX_pc_i;
    logic                ID_run_o;
    logic                flush_IF_o;
    logic                flush_ID_o;
    logic                ex_bubble_o;
    logic                redirect_valid_o;
    logic [PC_WIDTH-1:0] redirect_pc_o;
    logic                trap_valid_o;
    logic [PC_WIDTH-1:0] trap_epc_o;
    logic [3:0]          trap_cause_o;
    logic                busy_o;

    // Pipeline side: drives stage status, receives controls.
    modport master (
        output ID_valid_i, ID_pc_i, ID_pc_misalign_i, ID_if_bus_err_i,
               ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               EX_valid_i, EX_load_i, EX_rd_i, EX_br_valid_i, EX_br_taken_i,
               EX_prdt_taken_i, EX_br_target_i, EX_pc_i,
        input  ID_run_o, flush_IF_o, flush_ID_o, ex_bubble_o,
               redirect_valid_o, redirect_pc_o, trap_valid_o, trap_epc_o,
               trap_cause_o, busy_o
    );

    // Controller side.
    modport slave (
        input  ID_valid_i, ID_pc_i, ID_pc_misalign_i, ID_if_bus_err_i,
               ID_rs1_i, ID_rs2_i, ID_rs1_used_i, ID_rs2_used_i,
               EX_valid_i, EX_load_i, EX_rd_i, EX_br_valid_i, EX_br_taken_i,
               EX_prdt_taken_i, EX_br_target_i, EX_pc_i,
        output ID_run_o, flush_IF_o, flush_ID_o, ex_bubble_o,
               redirect_valid_o, redirect_pc_o, trap_valid_o, trap_epc_o,
               trap_cause_o, busy_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// IF/ID/EX sequencing controller: mispredict redirect, load-use stall and
// the fetch-exception drain/trap sequence (RUN -> DRAIN -> TRAP -> RUN).
module pipe_ctrl #(
    parameter int                   PC_WIDTH     = 32,
    parameter logic [PC_WIDTH-1:0]  TRAP_VEC     = 32'h0000_0100,
    parameter int                   DRAIN_CYCLES = 2
) (
    input  logic       clk,
    input  logic       rst,
    pipe_ctrl_if.slave bus
);
    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_TRAP  = 2'd2
    } state_t;

    localparam logic [3:0] DRAIN_LOAD = 4'(DRAIN_CYCLES - 1);

    state_t              state_q, state_d;
    logic [3:0]          cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] epc_q, epc_d;
    logic [3:0]          cause_q, cause_d;

    logic                mispredict;
    logic [PC_WIDTH-1:0] mp_pc;
    logic                fetch_exc;
    logic                rs_hit;
    logic                load_use;

    assign mispredict = bus.EX_valid_i & bus.EX_br_valid_i &
                        (bus.EX_br_taken_i != bus.EX_prdt_taken_i);
    // Not-taken correction resumes at the fall-through; wraps modulo 2^PC_WIDTH.
    assign mp_pc      = bus.EX_br_taken_i ? bus.EX_br_target_i
                                          : bus.EX_pc_i + PC_WIDTH'(4);
    assign fetch_exc  = bus.ID_valid_i & (bus.ID_pc_misalign_i | bus.ID_if_bus_err_i);
    assign rs_hit     = (bus.ID_rs1_used_i & (bus.ID_rs1_i == bus.EX_rd_i)) |
                        (bus.ID_rs2_used_i & (bus.ID_rs2_i == bus.EX_rd_i));
    assign load_use   = bus.EX_valid_i & bus.EX_load_i & (bus.EX_rd_i != 5'd0) &
                        bus.ID_valid_i & rs_hit;

    // Per-state controls and next state; everything is forced idle during reset.
    always_comb begin
        bus.ID_run_o         = 1'b1;
        bus.flush_IF_o       = 1'b0;
        bus.flush_ID_o       = 1'b0;
        bus.ex_bubble_o      = 1'b0;
        bus.redirect_valid_o = 1'b0;
        bus.redirect_pc_o    = '0;
        bus.trap_valid_o     = 1'b0;
        bus.trap_epc_o       = '0;
        bus.trap_cause_o     = 4'd0;
        bus.busy_o           = 1'b0;
        state_d              = state_q;
        cnt_d                = cnt_q;
        epc_d                = epc_q;
        cause_d              = cause_q;

        if (!rst) begin
            bus.busy_o = (state_q != ST_RUN);
            // A mispredict redirect wins in every state.
            if (mispredict) begin
                bus.redirect_valid_o = 1'b1;
                bus.redirect_pc_o    = mp_pc;
                bus.flush_IF_o       = 1'b1;
                bus.flush_ID_o       = 1'b1;
            end
            case (state_q)
                ST_RUN: begin
                    if (!mispredict && fetch_exc) begin
                        bus.flush_IF_o  = 1'b1;
                        bus.flush_ID_o  = 1'b1;
                        bus.ex_bubble_o = 1'b1;
                        state_d         = ST_DRAIN;
                        cnt_d           = DRAIN_LOAD;
                        epc_d           = bus.ID_pc_i;
                        cause_d         = bus.ID_pc_misalign_i ? 4'd0 : 4'd1;
                    end else if (!mispredict && load_use) begin
                        bus.ID_run_o    = 1'b0;
                        bus.ex_bubble_o = 1'b1;
                    end
                end
                ST_DRAIN: begin
                    bus.ID_run_o    = 1'b0;
                    bus.flush_IF_o  = 1'b1;
                    bus.flush_ID_o  = 1'b1;
                    bus.ex_bubble_o = 1'b1;
                    if (mispredict) begin
                        // An older branch redirected: the faulting instruction was wrong-path.
                        state_d = ST_RUN;
                        cnt_d   = 4'd0;
                        epc_d   = '0;
                        cause_d = 4'd0;
                    end else if (cnt_q == 4'd0) begin
                        state_d = ST_TRAP;
                    end else begin
                        cnt_d = cnt_q - 4'd1;
                    end
                end
                ST_TRAP: begin
                    bus.ID_run_o         = 1'b0;
                    bus.flush_IF_o       = 1'b1;
                    bus.flush_ID_o       = 1'b1;
                    bus.redirect_valid_o = 1'b1;
                    if (!mispredict) begin
                        bus.redirect_pc_o = TRAP_VEC;
                        bus.trap_valid_o  = 1'b1;
                        bus.trap_epc_o    = epc_q;
                        bus.trap_cause_o  = cause_q;
                    end
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                    epc_d   = '0;
                    cause_d = 4'd0;
                end
                default: begin
                    state_d = ST_RUN;
                    cnt_d   = 4'd0;
                    epc_d   = '0;
                    cause_d = 4'd0;
                end
            endcase
        end
    end

    // Controller state: FSM, drain counter and captured exception info.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_RUN;
            cnt_q   <= 4'd0;
            epc_q   <= '0;
            cause_q <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            cause_q <= cause_d;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Bench for pipe_ctrl: directed scenarios with literal expectations plus
// random traffic checked every cycle against a cycle-count reference model.
module tb_pipe_ctrl;
    localparam int          PCW  = 32;
    localparam logic [31:0] TVEC = 32'h0000_0100;
    localparam int          DC   = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    pipe_ctrl_if #(.PC_WIDTH(PCW)) bus ();

    pipe_ctrl #(
        .PC_WIDTH    (PCW),
        .TRAP_VEC    (TVEC),
        .DRAIN_CYCLES(DC)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        chk32(name, 32'(act), 32'(exp));
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.ID_valid_i       = 1'b0;
        bus.ID_pc_i          = '0;
        bus.ID_pc_misalign_i = 1'b0;
        bus.ID_if_bus_err_i  = 1'b0;
        bus.ID_rs1_i         = 5'd0;
        bus.ID_rs2_i         = 5'd0;
        bus.ID_rs1_used_i    = 1'b0;
        bus.ID_rs2_used_i    = 1'b0;
        bus.EX_valid_i       = 1'b0;
        bus.EX_load_i        = 1'b0;
        bus.EX_rd_i          = 5'd0;
        bus.EX_br_valid_i    = 1'b0;
        bus.EX_br_taken_i    = 1'b0;
        bus.EX_prdt_taken_i  = 1'b0;
        bus.EX_br_target_i   = '0;
        bus.EX_pc_i          = '0;
    endtask

    task automatic rand_inputs();
        bus.ID_valid_i       = 1'($urandom_range(0, 1));
        bus.ID_pc_i          = $urandom;
        bus.ID_pc_misalign_i = ($urandom_range(0, 15) == 0);
        bus.ID_if_bus_err_i  = ($urandom_range(0, 15) == 0);
        bus.ID_rs1_i         = 5'($urandom_range(0, 3));
        bus.ID_rs2_i         = 5'($urandom_range(0, 3));
        bus.ID_rs1_used_i    = 1'($urandom_range(0, 1));
        bus.ID_rs2_used_i    = 1'($urandom_range(0, 1));
        bus.EX_valid_i       = 1'($urandom_range(0, 1));
        bus.EX_load_i        = 1'($urandom_range(0, 1));
        bus.EX_rd_i          = 5'($urandom_range(0, 3));
        bus.EX_br_valid_i    = ($urandom_range(0, 5) == 0);
        bus.EX_br_taken_i    = 1'($urandom_range(0, 1));
        bus.EX_prdt_taken_i  = 1'($urandom_range(0, 1));
        bus.EX_br_target_i   = $urandom;
        bus.EX_pc_i          = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFC : $urandom;
    endtask

    task automatic set_mispredict(input logic [31:0] pc, input logic taken,
                                  input logic [31:0] tgt);
        bus.EX_valid_i      = 1'b1;
        bus.EX_br_valid_i   = 1'b1;
        bus.EX_br_taken_i   = taken;
        bus.EX_prdt_taken_i = ~taken;
        bus.EX_pc_i         = pc;
        bus.EX_br_target_i  = tgt;
    endtask

    task automatic set_exc(input logic [31:0] pc, input logic mis, input logic berr);
        bus.ID_valid_i       = 1'b1;
        bus.ID_pc_i          = pc;
        bus.ID_pc_misalign_i = mis;
        bus.ID_if_bus_err_i  = berr;
    endtask

    // ---------------- reference model + scoreboard ----------------
    // Pending trap is tracked as "cycles since the exception was taken"
    // (0 = none); cycles 1..DC are drain, cycle DC+1 is the trap commit.
    int          since = 0;
    logic [3:0]  m_cause = 4'd0;
    logic [31:0] exp_q[$];

    logic        e_run, e_fif, e_fid, e_bub, e_rv, e_tv, e_busy;
    logic [31:0] e_rpc, e_epc;
    logic [3:0]  e_cause;

    // Compare process: derive the expected outputs from the rules, compare, then advance.
    always @(negedge clk) begin
        logic        mp, exc, lu;
        logic [31:0] mp_pc;
        mp    = bus.EX_valid_i & bus.EX_br_valid_i & (bus.EX_br_taken_i != bus.EX_prdt_taken_i);
        mp_pc = bus.EX_br_taken_i ? bus.EX_br_target_i : bus.EX_pc_i + 32'd4;
        exc   = 1'b0;
        lu    = 1'b0;
        e_run = 1'b1; e_fif = 1'b0; e_fid = 1'b0; e_bub = 1'b0; e_rv = 1'b0;
        e_tv  = 1'b0; e_busy = 1'b0; e_rpc = '0; e_epc = '0; e_cause = 4'd0;
        if (!rst) begin
            e_busy = (since != 0);
            if (mp) begin
                e_rv = 1'b1; e_rpc = mp_pc; e_fif = 1'b1; e_fid = 1'b1;
            end
            if (since == 0) begin
                exc = !mp && bus.ID_valid_i && (bus.ID_pc_misalign_i || bus.ID_if_bus_err_i);
                lu  = !mp && !exc && bus.EX_valid_i && bus.EX_load_i && bus.EX_rd_i != 0 &&
                      bus.ID_valid_i &&
                      ((bus.ID_rs1_used_i && bus.ID_rs1_i == bus.EX_rd_i) ||
                       (bus.ID_rs2_used_i && bus.ID_rs2_i == bus.EX_rd_i));
                if (exc) begin e_fif = 1'b1; e_fid = 1'b1; e_bub = 1'b1; end
                if (lu)  begin e_run = 1'b0; e_bub = 1'b1; end
            end else if (since <= DC) begin
                e_run = 1'b0; e_fif = 1'b1; e_fid = 1'b1; e_bub = 1'b1;
            end else begin
                e_run = 1'b0; e_fif = 1'b1; e_fid = 1'b1; e_rv = 1'b1;
                if (!mp) begin
                    e_rpc = TVEC; e_tv = 1'b1; e_epc = exp_q[0]; e_cause = m_cause;
                end
            end
        end

        chk1 ("ID_run",         bus.ID_run_o,         e_run);
        chk1 ("flush_IF",       bus.flush_IF_o,       e_fif);
        chk1 ("flush_ID",       bus.flush_ID_o,       e_fid);
        chk1 ("ex_bubble",      bus.ex_bubble_o,      e_bub);
        chk1 ("redirect_valid", bus.redirect_valid_o, e_rv);
        chk32("redirect_pc",    bus.redirect_pc_o,    e_rpc);
        chk1 ("trap_valid",     bus.trap_valid_o,     e_tv);
        chk32("trap_epc",       bus.trap_epc_o,       e_epc);
        chk32("trap_cause",     32'(bus.trap_cause_o), 32'(e_cause));
        chk1 ("busy",           bus.busy_o,           e_busy);

        // Advance the model to the next cycle.
        if (rst) begin
            since = 0;
            exp_q.delete();
        end else if (since == 0) begin
            if (exc) begin
                since   = 1;
                exp_q.push_back(bus.ID_pc_i);
                m_cause = bus.ID_pc_misalign_i ? 4'd0 : 4'd1;
            end
        end else if (since <= DC && !mp) begin
            since++;
        end else begin
            since = 0;
            if (exp_q.size() != 0) void'(exp_q.pop_front());
        end
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        idle();
        // Reset held 3 cycles with random inputs.
        rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            rand_inputs();
            @(negedge clk);
            chk1("rst_ID_run", bus.ID_run_o, 1'b1);
            chk1("rst_redirect", bus.redirect_valid_o, 1'b0);
            tick();
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        chk1("post_rst_busy", bus.busy_o, 1'b0);
        chk1("post_rst_run", bus.ID_run_o, 1'b1);
        tick();

        // Mispredict: predicted taken, actually not taken.
        set_mispredict(32'h80, 1'b0, 32'h1234);
        @(negedge clk);
        chk1 ("mp1_valid", bus.redirect_valid_o, 1'b1);
        chk32("mp1_pc", bus.redirect_pc_o, 32'h84);
        chk1 ("mp1_fif", bus.flush_IF_o, 1'b1);
        chk1 ("mp1_fid", bus.flush_ID_o, 1'b1);
        tick();
        idle();
        set_mispredict(32'h80, 1'b1, 32'h200);
        @(negedge clk);
        chk32("mp2_pc", bus.redirect_pc_o, 32'h200);
        tick();

        // Load-use on rs2.
        idle();
        bus.EX_valid_i = 1'b1; bus.EX_load_i = 1'b1; bus.EX_rd_i = 5'd5;
        bus.ID_valid_i = 1'b1; bus.ID_rs2_i = 5'd5; bus.ID_rs2_used_i = 1'b1;
        bus.ID_rs1_i = 5'd5; bus.ID_rs1_used_i = 1'b0;
        @(negedge clk);
        chk1("lu_run", bus.ID_run_o, 1'b0);
        chk1("lu_bubble", bus.ex_bubble_o, 1'b1);
        tick();
        bus.EX_load_i = 1'b0;
        @(negedge clk);
        chk1("lu_release", bus.ID_run_o, 1'b1);
        tick();
        // Negative: rd = 0, then rs2 unused.
        bus.EX_load_i = 1'b1; bus.EX_rd_i = 5'd0; bus.ID_rs2_i = 5'd0;
        @(negedge clk);
        chk1("lu_rd0", bus.ID_run_o, 1'b1);
        tick();
        bus.EX_rd_i = 5'd5; bus.ID_rs2_i = 5'd5; bus.ID_rs2_used_i = 1'b0;
        @(negedge clk);
        chk1("lu_unused", bus.ID_run_o, 1'b1);
        tick();

        // Fetch exception with both flags: misalign cause wins.
        idle();
        set_exc(32'h102, 1'b1, 1'b1);
        @(negedge clk);
        chk1("exc_T_fid", bus.flush_ID_o, 1'b1);
        chk1("exc_T_busy", bus.busy_o, 1'b0);
        tick();
        idle();
        for (int i = 1; i <= 2; i++) begin
            @(negedge clk);
            chk1("exc_drain_busy", bus.busy_o, 1'b1);
            chk1("exc_drain_run", bus.ID_run_o, 1'b0);
            tick();
        end
        @(negedge clk);
        chk1 ("exc_trap_valid", bus.trap_valid_o, 1'b1);
        chk32("exc_trap_rpc", bus.redirect_pc_o, 32'h100);
        chk32("exc_trap_epc", bus.trap_epc_o, 32'h102);
        chk32("exc_trap_cause", 32'(bus.trap_cause_o), 32'd0);
        tick();
        @(negedge clk);
        chk1("exc_resume_run", bus.ID_run_o, 1'b1);
        chk1("exc_resume_busy", bus.busy_o, 1'b0);
        tick();

        // Abort: exception then mispredict during drain.
        set_exc(32'h10, 1'b0, 1'b1);
        tick();
        idle();
        set_mispredict(32'h8, 1'b1, 32'h40);
        @(negedge clk);
        chk32("abort_rpc", bus.redirect_pc_o, 32'h40);
        tick();
        idle();
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk1("abort_busy", bus.busy_o, 1'b0);
            chk1("abort_no_trap", bus.trap_valid_o, 1'b0);
            tick();
        end

        // Mispredict and exception together.
        set_exc(32'h20, 1'b1, 1'b0);
        set_mispredict(32'h30, 1'b0, 32'h0);
        @(negedge clk);
        chk32("sim_rpc", bus.redirect_pc_o, 32'h34);
        tick();
        idle();
        @(negedge clk);
        chk1("sim_busy", bus.busy_o, 1'b0);
        tick();

        // Reset during drain.
        set_exc(32'h44, 1'b0, 1'b1);
        tick();
        idle();
        tick();
        rst = 1'b1;
        @(negedge clk);
        chk1("rst_drain_trap", bus.trap_valid_o, 1'b0);
        tick();
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk1("rst_drain_no_trap", bus.trap_valid_o, 1'b0);
            chk1("rst_drain_busy", bus.busy_o, 1'b0);
            tick();
        end

        // Random traffic, checked every cycle by the model.
        for (int i = 0; i < 3000; i++) begin
            rand_inputs();
            rst = ($urandom_range(0, 199) == 0);
            tick();
        end
        rst = 1'b0;
        idle();
        @(negedge clk);
        #1;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
